wb_data_arbiter: RTL and testbench

Two-master, one-slave Wishbone pipelined arbiter sharing the core's data bus with a second master (DMA or debug loader) ahead of the data-side address decoder. Round-robin grant is held for a whole bus cycle (`cyc`). Outstanding accepted strobes are tracked so a grant never changes while responses are still owed. Requests and responses are routed combinationally once granted, with one cycle of arbitration latency.

---
 rtl/wb_data_arbiter_if.sv | 25 ++
 rtl/wb_data_arbiter.sv | 166 ++++++++++++++++
 tb/tb_wb_data_arbiter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_data_arbiter_if.sv
// rtl/wb_data_arbiter_if.sv - Wishbone pipelined bus bundle with master/slave modports
interface wb_data_arbiter_if;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [31:0] adr;
   logic [31:0] dat_w;
   logic [3:0]  sel;
   logic        stall;
   logic        ack;
   logic        err;
   logic [31:0] dat_r;

   // Bus initiator side: drives the request, receives the response
   modport master (
      output cyc, stb, we, adr, dat_w, sel,
      input  stall, ack, err, dat_r
   );

   // Bus target side: receives the request, drives the response
   modport slave (
      input  cyc, stb, we, adr, dat_w, sel,
      output stall, ack, err, dat_r
   );
endinterface

// File: rtl/wb_data_arbiter.sv
// rtl/wb_data_arbiter.sv - two-master round-robin Wishbone pipelined arbiter (optional watchdog: WB_ARB_TIMEOUT_EN)
module wb_data_arbiter #(
   parameter int MAX_OUTSTANDING = 4,
   parameter int TIMEOUT_CYCLES  = 255
) (
   input  logic              clk_i,
   input  logic              reset_i,
   wb_data_arbiter_if.slave  m0_wb,
   wb_data_arbiter_if.slave  m1_wb,
   wb_data_arbiter_if.master s_wb,
   output logic [1:0]        grant_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GNT0 = 2'd1,
      ST_GNT1 = 2'd2
   } state_t;

   localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

   // Elaboration-time guard on parameter ranges
   generate
      if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 15) begin : g_bad_max
         $error("MAX_OUTSTANDING must be 1..15");
      end
      if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
         $error("TIMEOUT_CYCLES must be 1..65535");
      end
   endgenerate

   state_t     r_state;
   state_t     w_state_nxt;
   logic       r_last;
   logic [3:0] r_out_cnt;
   logic [3:0] w_out_cnt_nxt;
   logic       w_gnt_cyc;
   logic       w_full;
   logic       w_cnt_nz;
   logic       w_resp;
   logic       w_accept;
   logic       w_timeout;

   assign w_full   = (r_out_cnt == MAX_CNT);
   assign w_cnt_nz = (r_out_cnt != 4'd0);
   // Responses with nothing owed are stray and never counted or forwarded
   assign w_resp   = (s_wb.ack | s_wb.err) & w_cnt_nz;
   // Slave-side strobe is already masked while full, so this is the granted master's accept
   assign w_accept = s_wb.stb & ~s_wb.stall;
   assign grant_o  = {r_state == ST_GNT1, r_state == ST_GNT0};

   // State register
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Arbitrate in IDLE, then hold the grant until its owner drops cyc
   always_comb begin
      w_state_nxt = r_state;
      w_gnt_cyc   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (m0_wb.cyc && m1_wb.cyc) w_state_nxt = r_last ? ST_GNT0 : ST_GNT1;
            else if (m0_wb.cyc)         w_state_nxt = ST_GNT0;
            else if (m1_wb.cyc)         w_state_nxt = ST_GNT1;
         end
         ST_GNT0: begin
            w_gnt_cyc = m0_wb.cyc;
            if (!m0_wb.cyc) w_state_nxt = ST_IDLE;
         end
         ST_GNT1: begin
            w_gnt_cyc = m1_wb.cyc;
            if (!m1_wb.cyc) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Remember who was granted last so a tie goes to the other master
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i)                                        r_last <= 1'b1;
      else if (r_state == ST_IDLE && w_state_nxt == ST_GNT0) r_last <= 1'b0;
      else if (r_state == ST_IDLE && w_state_nxt == ST_GNT1) r_last <= 1'b1;
   end

   // Outstanding count: abandoned on release or watchdog expiry
   always_comb begin
      w_out_cnt_nxt = r_out_cnt;
      if (r_state == ST_IDLE || !w_gnt_cyc || w_timeout) w_out_cnt_nxt = 4'd0;
      else if (w_accept && !w_resp)                      w_out_cnt_nxt = r_out_cnt + 4'd1;
      else if (w_resp && !w_accept)                      w_out_cnt_nxt = r_out_cnt - 4'd1;
   end

   // Outstanding count register
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) r_out_cnt <= 4'd0;
      else          r_out_cnt <= w_out_cnt_nxt;
   end

`ifdef WB_ARB_TIMEOUT_EN
   localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] r_wd;
   logic        w_wd_run;

   assign w_wd_run  = (r_state != ST_IDLE) & w_cnt_nz & ~(s_wb.ack | s_wb.err);
   assign w_timeout = w_wd_run & (r_wd == WD_LAST);

   // Watchdog: counts silent cycles while responses are owed
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i)                                           r_wd <= 16'd0;
      else if (!w_wd_run || w_timeout || w_state_nxt != r_state) r_wd <= 16'd0;
      else                                                    r_wd <= r_wd + 16'd1;
   end
`else
   assign w_timeout = 1'b0;
`endif

   // Route the granted master to the slave; the other master sees an idle bus
   always_comb begin
      s_wb.cyc    = 1'b0;
      s_wb.stb    = 1'b0;
      s_wb.we     = 1'b0;
      s_wb.adr    = 32'd0;
      s_wb.dat_w  = 32'd0;
      s_wb.sel    = 4'd0;
      m0_wb.stall = 1'b1;
      m0_wb.ack   = 1'b0;
      m0_wb.err   = 1'b0;
      m0_wb.dat_r = 32'd0;
      m1_wb.stall = 1'b1;
      m1_wb.ack   = 1'b0;
      m1_wb.err   = 1'b0;
      m1_wb.dat_r = 32'd0;
      case (r_state)
         ST_GNT0: begin
            s_wb.cyc    = m0_wb.cyc;
            // Masked when full so the slave never takes a strobe the master saw stalled
            s_wb.stb    = m0_wb.stb & ~w_full;
            s_wb.we     = m0_wb.we;
            s_wb.adr    = m0_wb.adr;
            s_wb.dat_w  = m0_wb.dat_w;
            s_wb.sel    = m0_wb.sel;
            m0_wb.stall = s_wb.stall | w_full;
            m0_wb.ack   = s_wb.ack & w_cnt_nz;
            m0_wb.err   = (s_wb.err & w_cnt_nz) | w_timeout;
            m0_wb.dat_r = s_wb.dat_r;
         end
         ST_GNT1: begin
            s_wb.cyc    = m1_wb.cyc;
            s_wb.stb    = m1_wb.stb & ~w_full;
            s_wb.we     = m1_wb.we;
            s_wb.adr    = m1_wb.adr;
            s_wb.dat_w  = m1_wb.dat_w;
            s_wb.sel    = m1_wb.sel;
            m1_wb.stall = s_wb.stall | w_full;
            m1_wb.ack   = s_wb.ack & w_cnt_nz;
            m1_wb.err   = (s_wb.err & w_cnt_nz) | w_timeout;
            m1_wb.dat_r = s_wb.dat_r;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_wb_data_arbiter.sv
// tb/tb_wb_data_arbiter.sv - self-checking bench for wb_data_arbiter
module tb_wb_data_arbiter;
   localparam int MAXO = 4;
   localparam int TO   = 8;

   logic       clk = 1'b0;
   logic       reset_i;
   logic [1:0] grant;

   always #5 clk = ~clk;

   wb_data_arbiter_if m0_if ();
   wb_data_arbiter_if m1_if ();
   wb_data_arbiter_if s_if ();

   wb_data_arbiter #(.MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TO)) dut (
      .clk_i   (clk),
      .reset_i (reset_i),
      .m0_wb   (m0_if),
      .m1_wb   (m1_if),
      .s_wb    (s_if),
      .grant_o (grant)
   );

   int n_checks = 0;
   int n_err    = 0;

   localparam logic [142:0] IDLE_OUTS = {71'd0, 1'b1, 34'd0, 1'b1, 34'd0, 2'b00};

   typedef struct packed {
      logic [5:0] in;   // m0 cyc, m0 stb, m1 cyc, m1 stb, slave stall, slave ack
      logic [6:0] exp;  // grant[1:0], m0 stall, m1 stall, m0 ack, m1 ack, slave stb
   } vec_t;
   vec_t tbl [25];

   task automatic check(input string name, input logic [142:0] act, input logic [142:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [142:0] dut_outs();
      return {s_if.cyc, s_if.stb, s_if.we, s_if.adr, s_if.dat_w, s_if.sel,
              m0_if.stall, m0_if.ack, m0_if.err, m0_if.dat_r,
              m1_if.stall, m1_if.ack, m1_if.err, m1_if.dat_r, grant};
   endfunction

   task automatic clear_inputs();
      {m0_if.cyc, m0_if.stb, m0_if.we, m0_if.adr, m0_if.dat_w, m0_if.sel} = '0;
      {m1_if.cyc, m1_if.stb, m1_if.we, m1_if.adr, m1_if.dat_w, m1_if.sel} = '0;
      {s_if.stall, s_if.ack, s_if.err, s_if.dat_r} = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_i = 1'b0;
      clear_inputs();
      @(posedge clk);
      @(posedge clk);
      #1 reset_i = 1'b1;
   endtask

   // Reference model state: owner -1 means nobody holds the bus
   int mo_owner, mo_cnt, mo_silent;
   bit mo_last;
   bit rc0, rc1;

   initial begin : watchdog
      #500000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin : main
      int first_err, err_cycles, exp_first, exp_errs, exp_cnt;
      logic [142:0] exp;
      logic [70:0]  sv;
      logic [34:0]  r0, r1;
      logic [1:0]   ge;
      logic         full, tmo, owed, sstb, accepted, answered;

      tbl[0]  = {6'b111100, 7'b0011000};
      tbl[1]  = {6'b111100, 7'b0101001};
      tbl[2]  = {6'b111101, 7'b0101101};
      tbl[3]  = {6'b101001, 7'b0101100};
      tbl[4]  = {6'b101001, 7'b0101000};
      tbl[5]  = {6'b001100, 7'b0101000};
      tbl[6]  = {6'b001100, 7'b0011000};
      tbl[7]  = {6'b001100, 7'b1010001};
      tbl[8]  = {6'b111100, 7'b1010001};
      tbl[9]  = {6'b111100, 7'b1010001};
      tbl[10] = {6'b111100, 7'b1010001};
      tbl[11] = {6'b111100, 7'b1011000};
      tbl[12] = {6'b111101, 7'b1011010};
      tbl[13] = {6'b111100, 7'b1010001};
      tbl[14] = {6'b111100, 7'b1011000};
      tbl[15] = {6'b100000, 7'b1011000};
      tbl[16] = {6'b100001, 7'b0011000};
      tbl[17] = {6'b100001, 7'b0101000};
      tbl[18] = {6'b101000, 7'b0101000};
      tbl[19] = {6'b001000, 7'b0101000};
      tbl[20] = {6'b101000, 7'b0011000};
      tbl[21] = {6'b101000, 7'b1010000};
      tbl[22] = {6'b100000, 7'b1010000};
      tbl[23] = {6'b100000, 7'b0011000};
      tbl[24] = {6'b100000, 7'b0101000};

      // Reset state
      reset_i = 1'b0;
      clear_inputs();
      #3;
      check("reset_outputs", dut_outs(), IDLE_OUTS);
      do_reset();

      // Table: contention, back-to-back, outstanding limit, stray acks
      m0_if.adr = 32'h0000_1000;
      m1_if.adr = 32'h0000_2000;
      for (int i = 0; i < 25; i++) begin
         {m0_if.cyc, m0_if.stb, m1_if.cyc, m1_if.stb, s_if.stall, s_if.ack} = tbl[i].in;
         @(negedge clk);
         check($sformatf("table[%0d]", i),
               143'({grant, m0_if.stall, m1_if.stall, m0_if.ack, m1_if.ack, s_if.stb}),
               143'(tbl[i].exp));
         tick();
      end

      // Single read request routed and answered
      do_reset();
      m0_if.cyc = 1'b1; m0_if.stb = 1'b1; m0_if.sel = 4'hF; m0_if.adr = 32'h0001_0004;
      @(negedge clk);
      check("single_idle_grant", 143'(grant), 143'(2'b00));
      tick();
      @(negedge clk);
      check("single_request", 143'({grant, s_if.adr, s_if.stb, m0_if.stall}),
            143'({2'b01, 32'h0001_0004, 1'b1, 1'b0}));
      tick();
      m0_if.stb = 1'b0; s_if.ack = 1'b1; s_if.dat_r = 32'hDEAD_BEEF;
      @(negedge clk);
      check("single_response", 143'({m0_if.ack, m0_if.dat_r, m1_if.ack}),
            143'({1'b1, 32'hDEAD_BEEF, 1'b0}));
      tick();

      // Abort with three owed responses, then a late ack in IDLE
      do_reset();
      m1_if.cyc = 1'b1; m1_if.stb = 1'b1;
      tick();
      tick(); tick(); tick();
      m1_if.cyc = 1'b0; m1_if.stb = 1'b0;
      @(negedge clk);
      check("abort_owed", 143'(dut.r_out_cnt), 143'(3));
      tick();
      s_if.ack = 1'b1;
      @(negedge clk);
      check("abort_late_ack", 143'({grant, m0_if.ack, m1_if.ack, dut.r_out_cnt}),
            143'({2'b00, 1'b0, 1'b0, 4'd0}));
      tick();

      // Reset asserted mid-cycle while granted with two owed responses
      do_reset();
      m0_if.cyc = 1'b1; m0_if.stb = 1'b1;
      tick(); tick(); tick();
      m0_if.stb = 1'b0;
      #2 reset_i = 1'b0;
      #1;
      check("midreset_outputs", dut_outs(), IDLE_OUTS);
      check("midreset_count", 143'(dut.r_out_cnt), 143'(0));
      clear_inputs();
      @(posedge clk);
      #1 reset_i = 1'b1;

      // Silent slave after one accepted strobe
      do_reset();
      m0_if.cyc = 1'b1; m0_if.stb = 1'b1;
      tick();
      tick();
      m0_if.stb  = 1'b0;
      first_err  = -1;
      err_cycles = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (m0_if.err) begin
            err_cycles++;
            if (first_err < 0) first_err = k;
         end
         tick();
      end
`ifdef WB_ARB_TIMEOUT_EN
      exp_first = TO; exp_errs = 1; exp_cnt = 0;
`else
      exp_first = -1; exp_errs = 0; exp_cnt = 1;
`endif
      check("timeout_cycle", 143'(first_err), 143'(exp_first));
      check("timeout_pulses", 143'(err_cycles), 143'(exp_errs));
      check("timeout_count", 143'(dut.r_out_cnt), 143'(exp_cnt));
      m0_if.cyc = 1'b0;
      tick();

      // Random traffic against the reference model
      do_reset();
      mo_owner = -1; mo_last = 1'b1; mo_cnt = 0; mo_silent = 0;
      rc0 = 1'b0; rc1 = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         rc0 = rc0 ? ($urandom_range(15) != 0) : ($urandom_range(3) == 0);
         rc1 = rc1 ? ($urandom_range(15) != 0) : ($urandom_range(3) == 0);
         m0_if.cyc = rc0; m0_if.stb = rc0 & 1'($urandom_range(1)); m0_if.we = 1'($urandom_range(1));
         m0_if.adr = $urandom; m0_if.dat_w = $urandom; m0_if.sel = 4'($urandom);
         m1_if.cyc = rc1; m1_if.stb = rc1 & 1'($urandom_range(1)); m1_if.we = 1'($urandom_range(1));
         m1_if.adr = $urandom; m1_if.dat_w = $urandom; m1_if.sel = 4'($urandom);
         s_if.stall = ($urandom_range(3) == 0);
         s_if.ack   = ((i / 250) % 2 == 0) ? ($urandom_range(2) == 0) : ($urandom_range(9) == 0);
         s_if.err   = ($urandom_range(15) == 0);
         s_if.dat_r = $urandom;
         @(negedge clk);

         full = (mo_cnt == MAXO);
         owed = (mo_cnt > 0);
         tmo  = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
         tmo = (mo_owner >= 0) && owed && !(s_if.ack || s_if.err) && (mo_silent + 1 == TO);
`endif
         sstb = 1'b0;
         sv   = '0;
         r0   = {1'b1, 34'd0};
         r1   = {1'b1, 34'd0};
         ge   = 2'b00;
         if (mo_owner == 0) begin
            sstb = m0_if.stb && !full;
            sv   = {m0_if.cyc, sstb, m0_if.we, m0_if.adr, m0_if.dat_w, m0_if.sel};
            r0   = {s_if.stall || full, s_if.ack && owed, (s_if.err && owed) || tmo, s_if.dat_r};
            ge   = 2'b01;
         end else if (mo_owner == 1) begin
            sstb = m1_if.stb && !full;
            sv   = {m1_if.cyc, sstb, m1_if.we, m1_if.adr, m1_if.dat_w, m1_if.sel};
            r1   = {s_if.stall || full, s_if.ack && owed, (s_if.err && owed) || tmo, s_if.dat_r};
            ge   = 2'b10;
         end
         exp = {sv, r0, r1, ge};
         check($sformatf("random[%0d]", i), dut_outs(), exp);

         if (mo_owner < 0) begin
            if (m0_if.cyc && m1_if.cyc) mo_owner = mo_last ? 0 : 1;
            else if (m0_if.cyc)         mo_owner = 0;
            else if (m1_if.cyc)         mo_owner = 1;
            if (mo_owner >= 0) mo_last = (mo_owner == 1);
            mo_cnt = 0; mo_silent = 0;
         end else if (!((mo_owner == 0) ? m0_if.cyc : m1_if.cyc)) begin
            mo_owner = -1; mo_cnt = 0; mo_silent = 0;
         end else begin
            accepted  = sstb && !s_if.stall;
            answered  = (s_if.ack || s_if.err) && owed;
            mo_silent = (!tmo && owed && !(s_if.ack || s_if.err)) ? mo_silent + 1 : 0;
            mo_cnt    = mo_cnt + (accepted ? 1 : 0) - (answered ? 1 : 0);
            if (tmo) mo_cnt = 0;
         end
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
